rrv64_l1_mshr_file: RTL and testbench

Parametrised miss-status holding register file shared by the L1 I$ and D$ miss paths. It generalises the single-entry valid/cnt/tag MSHR record to NUM_ENTRY entries, each with its own lifecycle state machine. Secondary misses to an in-flight line are merged. Refill requests to the next level are issued, and merged requests are replayed one per cycle after refill. It sits between the L1 miss detector and the L1-to-L2 request/refill channel.

---
 rtl/rrv64_core_typedef_pkg.sv | 23 ++
 rtl/rrv64_prio_enc.sv | 25 ++
 rtl/rrv64_l1_mshr_file.sv | 186 ++++++++++++++++++
 tb/tb_rrv64_l1_mshr_file.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrv64_core_typedef_pkg.sv
// Shared L1 core typedefs: MSHR lifecycle state, entry record and default sizing.
package rrv64_core_typedef_pkg;

  localparam int RRV64_MSHR_NUM_ENTRY   = 4;
  localparam int RRV64_MSHR_MAX_MERGE   = 4;
  localparam int RRV64_MSHR_LINE_ADDR_W = 34;
  localparam int RRV64_MSHR_CNT_W       = $clog2(RRV64_MSHR_MAX_MERGE + 1);

  typedef enum logic [1:0] {
    MSHR_FREE  = 2'd0,
    MSHR_ISSUE = 2'd1,
    MSHR_WAIT  = 2'd2,
    MSHR_DRAIN = 2'd3
  } rrv64_mshr_state_e;

  // Default-width entry record; the MSHR file builds its own copy at its parameter widths.
  typedef struct packed {
    rrv64_mshr_state_e                   state;
    logic [RRV64_MSHR_CNT_W-1:0]         cnt;
    logic [RRV64_MSHR_LINE_ADDR_W-1:0]   line_addr;
  } rrv64_mshr_entry_t;

endpackage

// File: rtl/rrv64_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and any-request flag.
module rrv64_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rrv64_l1_mshr_file.sv
// L1 miss-status holding register file: allocate/merge misses, issue refills, replay merged requests.
module rrv64_l1_mshr_file
  import rrv64_core_typedef_pkg::*;
#(
  parameter int NUM_ENTRY   = RRV64_MSHR_NUM_ENTRY,
  parameter int LINE_ADDR_W = RRV64_MSHR_LINE_ADDR_W,
  parameter int MAX_MERGE   = RRV64_MSHR_MAX_MERGE,
  parameter int ID_W        = $clog2(NUM_ENTRY),
  parameter int CNT_W       = $clog2(MAX_MERGE + 1),
  parameter int OCC_W       = $clog2(NUM_ENTRY + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_vld_i,
  input  logic [LINE_ADDR_W-1:0] alloc_line_addr_i,
  output logic                   alloc_rdy_o,
  output logic                   alloc_merge_o,
  output logic [ID_W-1:0]        alloc_idx_o,
  output logic                   mem_req_vld_o,
  input  logic                   mem_req_rdy_i,
  output logic [LINE_ADDR_W-1:0] mem_req_line_addr_o,
  output logic [ID_W-1:0]        mem_req_id_o,
  input  logic                   refill_vld_i,
  input  logic [ID_W-1:0]        refill_id_i,
  output logic                   replay_vld_o,
  input  logic                   replay_rdy_i,
  output logic [ID_W-1:0]        replay_id_o,
  output logic [LINE_ADDR_W-1:0] replay_line_addr_o,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [OCC_W-1:0]       occupancy_o,
  output logic                   refill_err_o
);

  typedef struct packed {
    rrv64_mshr_state_e      state;
    logic [CNT_W-1:0]       cnt;
    logic [LINE_ADDR_W-1:0] line_addr;
  } entry_t;

  entry_t ent_q [NUM_ENTRY];
  entry_t ent_d [NUM_ENTRY];

  logic [NUM_ENTRY-1:0] free_vec, issue_vec, drain_vec, hit_vec;
  logic [NUM_ENTRY-1:0] issue_req, drain_req;
  logic [NUM_ENTRY-1:0] free_oh, issue_oh, drain_oh;
  logic [ID_W-1:0]      free_idx, issue_idx, drain_idx, hit_idx;
  logic                 free_any, issue_any, drain_any, hit_any;

  // A presented request/replay is pinned so a lower entry becoming eligible cannot swap it out.
  logic                 iss_lock_q, drn_lock_q;
  logic [NUM_ENTRY-1:0] iss_lock_oh_q, drn_lock_oh_q;

  logic                 mem_hs, replay_hs, refill_ok;
  logic                 full_d, empty_d;
  logic [OCC_W-1:0]     occ_d;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      free_vec[i]  = (ent_q[i].state == MSHR_FREE);
      issue_vec[i] = (ent_q[i].state == MSHR_ISSUE);
      drain_vec[i] = (ent_q[i].state == MSHR_DRAIN);
      hit_vec[i]   = !free_vec[i] && (ent_q[i].line_addr == alloc_line_addr_i);
      if (hit_vec[i]) hit_idx = hit_idx | ID_W'(i);
    end
    hit_any   = |hit_vec;
    issue_req = iss_lock_q ? iss_lock_oh_q : issue_vec;
    drain_req = drn_lock_q ? drn_lock_oh_q : drain_vec;
  end

  rrv64_prio_enc #(.N(NUM_ENTRY), .IDX_W(ID_W)) u_free_sel (
    .req(free_vec), .onehot(free_oh), .idx(free_idx), .any(free_any)
  );

  rrv64_prio_enc #(.N(NUM_ENTRY), .IDX_W(ID_W)) u_issue_sel (
    .req(issue_req), .onehot(issue_oh), .idx(issue_idx), .any(issue_any)
  );

  rrv64_prio_enc #(.N(NUM_ENTRY), .IDX_W(ID_W)) u_drain_sel (
    .req(drain_req), .onehot(drain_oh), .idx(drain_idx), .any(drain_any)
  );

  // A hit in DRAIN or at the merge limit stalls rather than allocating a duplicate line.
  always_comb begin
    alloc_rdy_o = 1'b0;
    if (alloc_vld_i && !flush_i) begin
      if (hit_any)
        alloc_rdy_o = (ent_q[hit_idx].state == MSHR_ISSUE || ent_q[hit_idx].state == MSHR_WAIT) &&
                      (ent_q[hit_idx].cnt < CNT_W'(MAX_MERGE));
      else
        alloc_rdy_o = free_any;
    end
    alloc_merge_o = alloc_rdy_o && hit_any;
    alloc_idx_o   = hit_any ? hit_idx : free_idx;
  end

  assign mem_req_vld_o       = issue_any;
  assign mem_req_id_o        = issue_idx;
  assign mem_req_line_addr_o = ent_q[issue_idx].line_addr;
  assign replay_vld_o        = drain_any;
  assign replay_id_o         = drain_idx;
  assign replay_line_addr_o  = ent_q[drain_idx].line_addr;

  assign mem_hs    = issue_any && mem_req_rdy_i;
  assign replay_hs = drain_any && replay_rdy_i;

  always_comb begin
    refill_ok = 1'b0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      ent_d[i] = ent_q[i];

      if (alloc_rdy_o && hit_vec[i])
        ent_d[i].cnt = ent_q[i].cnt + CNT_W'(1);
      if (alloc_rdy_o && !hit_any && free_oh[i]) begin
        ent_d[i].state     = MSHR_ISSUE;
        ent_d[i].cnt       = CNT_W'(1);
        ent_d[i].line_addr = alloc_line_addr_i;
      end

      // Flush wins over a same-cycle handshake: the request counts as never sent.
      if (ent_q[i].state == MSHR_ISSUE) begin
        if (flush_i) begin
          ent_d[i].state = MSHR_FREE;
          ent_d[i].cnt   = '0;
        end else if (mem_hs && issue_oh[i]) begin
          ent_d[i].state = MSHR_WAIT;
        end
      end

      if (refill_vld_i && refill_id_i == ID_W'(i) && ent_q[i].state == MSHR_WAIT) begin
        ent_d[i].state = MSHR_DRAIN;
        refill_ok      = 1'b1;
      end

      if (replay_hs && drain_oh[i]) begin
        if (ent_q[i].cnt == CNT_W'(1)) begin
          ent_d[i].state = MSHR_FREE;
          ent_d[i].cnt   = '0;
        end else begin
          ent_d[i].cnt = ent_q[i].cnt - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    occ_d  = '0;
    full_d = 1'b1;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (ent_d[i].state != MSHR_FREE) occ_d = occ_d + OCC_W'(1);
      else                             full_d = 1'b0;
    end
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        ent_q[i].state     <= MSHR_FREE;
        ent_q[i].cnt       <= '0;
        ent_q[i].line_addr <= '0;
      end
      iss_lock_q    <= 1'b0;
      iss_lock_oh_q <= '0;
      drn_lock_q    <= 1'b0;
      drn_lock_oh_q <= '0;
      full_o        <= 1'b0;
      empty_o       <= 1'b1;
      occupancy_o   <= '0;
      refill_err_o  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) ent_q[i] <= ent_d[i];
      iss_lock_q    <= issue_any && !mem_req_rdy_i && !flush_i;
      iss_lock_oh_q <= issue_oh;
      drn_lock_q    <= drain_any && !replay_rdy_i;
      drn_lock_oh_q <= drain_oh;
      full_o        <= full_d;
      empty_o       <= empty_d;
      occupancy_o   <= occ_d;
      refill_err_o  <= refill_vld_i && !refill_ok;
    end
  end

endmodule

// File: tb/tb_rrv64_l1_mshr_file.sv
// Randomized + directed bench for the MSHR file against a per-entry lifecycle reference model.
module tb_rrv64_l1_mshr_file;

  localparam int NE    = 4;
  localparam int MAXM  = 4;
  localparam int AW    = 34;
  localparam int S_FREE = 0, S_ISS = 1, S_WAIT = 2, S_DRN = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_vld_i;
  logic [AW-1:0] alloc_line_addr_i;
  logic          alloc_rdy_o, alloc_merge_o;
  logic [1:0]    alloc_idx_o;
  logic          mem_req_vld_o, mem_req_rdy_i;
  logic [AW-1:0] mem_req_line_addr_o;
  logic [1:0]    mem_req_id_o;
  logic          refill_vld_i;
  logic [1:0]    refill_id_i;
  logic          replay_vld_o, replay_rdy_i;
  logic [1:0]    replay_id_o;
  logic [AW-1:0] replay_line_addr_o;
  logic          flush_i, full_o, empty_o;
  logic [2:0]    occupancy_o;
  logic          refill_err_o;

  rrv64_l1_mshr_file dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_vld_i(alloc_vld_i), .alloc_line_addr_i(alloc_line_addr_i),
    .alloc_rdy_o(alloc_rdy_o), .alloc_merge_o(alloc_merge_o), .alloc_idx_o(alloc_idx_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_line_addr_o(mem_req_line_addr_o), .mem_req_id_o(mem_req_id_o),
    .refill_vld_i(refill_vld_i), .refill_id_i(refill_id_i),
    .replay_vld_o(replay_vld_o), .replay_rdy_i(replay_rdy_i),
    .replay_id_o(replay_id_o), .replay_line_addr_o(replay_line_addr_o),
    .flush_i(flush_i), .full_o(full_o), .empty_o(empty_o),
    .occupancy_o(occupancy_o), .refill_err_o(refill_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lifecycle per entry plus pinned issue/replay selections.
  int            m_st   [NE];
  int            m_cnt  [NE];
  logic [AW-1:0] m_addr [NE];
  int            m_iss_hold, m_rep_hold;
  bit            m_err;

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_st[i] = S_FREE; m_cnt[i] = 0; m_addr[i] = '0;
    end
    m_iss_hold = -1; m_rep_hold = -1; m_err = 1'b0;
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < NE; i++) if (m_st[i] != S_FREE) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int lowest_wait();
    for (int i = 0; i < NE; i++) if (m_st[i] == S_WAIT) return i;
    return -1;
  endfunction

  // One cycle: drive, check every output against the model, advance the model at the edge.
  task automatic step(input bit av, input logic [AW-1:0] aa, input bit mr,
                      input bit fv, input int fid, input bit rr, input bit fl);
    int hit, fr, iss, rep, occ;
    bit e_rdy, n_err;
    int n_st [NE];
    int n_cnt[NE];
    logic [AW-1:0] n_addr[NE];
    alloc_vld_i = av; alloc_line_addr_i = aa; mem_req_rdy_i = mr;
    refill_vld_i = fv; refill_id_i = fid[1:0]; replay_rdy_i = rr; flush_i = fl;
    #1;
    hit = -1; fr = -1; iss = -1; rep = -1; occ = 0;
    for (int i = 0; i < NE; i++) begin
      if (m_st[i] == S_FREE) begin
        if (fr < 0) fr = i;
      end else begin
        occ++;
        if (m_addr[i] == aa) hit = i;
      end
      if (m_st[i] == S_ISS && iss < 0) iss = i;
      if (m_st[i] == S_DRN && rep < 0) rep = i;
    end
    if (m_iss_hold >= 0) iss = m_iss_hold;
    if (m_rep_hold >= 0) rep = m_rep_hold;
    if (!av || fl)     e_rdy = 1'b0;
    else if (hit >= 0) e_rdy = (m_st[hit] == S_ISS || m_st[hit] == S_WAIT) && m_cnt[hit] < MAXM;
    else               e_rdy = (fr >= 0);

    chk("alloc_rdy", alloc_rdy_o, e_rdy);
    if (e_rdy) begin
      chk("alloc_merge", alloc_merge_o, hit >= 0);
      chk("alloc_idx", alloc_idx_o, (hit >= 0) ? hit : fr);
    end
    chk("mem_req_vld", mem_req_vld_o, iss >= 0);
    if (iss >= 0) begin
      chk("mem_req_id", mem_req_id_o, iss);
      chk("mem_req_addr", mem_req_line_addr_o, m_addr[iss]);
    end
    chk("replay_vld", replay_vld_o, rep >= 0);
    if (rep >= 0) begin
      chk("replay_id", replay_id_o, rep);
      chk("replay_addr", replay_line_addr_o, m_addr[rep]);
    end
    chk("full", full_o, fr < 0);
    chk("empty", empty_o, occ == 0);
    chk("occupancy", occupancy_o, occ);
    chk("refill_err", refill_err_o, m_err);

    for (int i = 0; i < NE; i++) begin
      n_st[i] = m_st[i]; n_cnt[i] = m_cnt[i]; n_addr[i] = m_addr[i];
    end
    if (e_rdy) begin
      if (hit >= 0) n_cnt[hit] = m_cnt[hit] + 1;
      else begin n_st[fr] = S_ISS; n_cnt[fr] = 1; n_addr[fr] = aa; end
    end
    for (int i = 0; i < NE; i++) begin
      if (m_st[i] == S_ISS) begin
        if (fl) begin n_st[i] = S_FREE; n_cnt[i] = 0; end
        else if (i == iss && mr) n_st[i] = S_WAIT;
      end
    end
    n_err = 1'b0;
    if (fv) begin
      if (fid < NE && m_st[fid] == S_WAIT) n_st[fid] = S_DRN;
      else n_err = 1'b1;
    end
    if (rep >= 0 && rr) begin
      n_cnt[rep] = m_cnt[rep] - 1;
      if (n_cnt[rep] == 0) n_st[rep] = S_FREE;
    end
    @(posedge clk);
    for (int i = 0; i < NE; i++) begin
      m_st[i] = n_st[i]; m_cnt[i] = n_cnt[i]; m_addr[i] = n_addr[i];
    end
    m_iss_hold = (iss >= 0 && !mr && !fl) ? iss : -1;
    m_rep_hold = (rep >= 0 && !rr) ? rep : -1;
    m_err = n_err;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain_all();
    int k, w;
    for (k = 0; k < 300 && !model_empty(); k++) begin
      w = lowest_wait();
      step(0, '0, 1, w >= 0, (w >= 0) ? w : 0, 1, 0);
    end
    if (!model_empty()) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int w, fid;
    bit fv;
    rst_n = 1'b0;
    alloc_vld_i = 0; alloc_line_addr_i = '0; mem_req_rdy_i = 0; refill_vld_i = 0;
    refill_id_i = '0; replay_rdy_i = 0; flush_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_mem_vld", mem_req_vld_o, 0);
    chk("rst_replay_vld", replay_vld_o, 0);
    chk("rst_alloc_rdy", alloc_rdy_o, 0);
    chk("rst_refill_err", refill_err_o, 0);
    rst_n = 1'b1;
    idle();

    // Primary miss, issue, three merges, stall at the merge limit, refill and four replays.
    step(1, 34'h100, 0, 0, 0, 0, 0);
    idle();
    step(0, '0, 1, 0, 0, 0, 0);
    repeat (3) step(1, 34'h100, 0, 0, 0, 0, 0);
    step(1, 34'h100, 0, 0, 0, 0, 0);
    chk("merge_limit_stall", alloc_rdy_o, 0);
    step(0, '0, 0, 1, 0, 0, 0);
    repeat (4) step(0, '0, 0, 0, 0, 1, 0);
    chk("drained_empty", empty_o, 1);
    idle();

    // Fill all entries, stall on a fifth line, free entry 2 and retry.
    for (int i = 0; i < 4; i++) step(1, 34'h10 + 34'(i), 1, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0, 0);
    step(1, 34'h14, 0, 0, 0, 0, 0);
    chk("full_flag", full_o, 1);
    step(0, '0, 0, 1, 2, 0, 0);
    step(0, '0, 0, 0, 0, 1, 0);
    step(1, 34'h14, 0, 0, 0, 0, 0);
    drain_all();

    // Flush drops only the not-yet-issued entry.
    step(1, 34'h200, 0, 0, 0, 0, 0);
    step(1, 34'h300, 0, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 1);
    idle();
    chk("flush_occ", occupancy_o, 1);
    drain_all();

    // Refill to a FREE entry: a single-cycle error pulse.
    step(0, '0, 0, 1, 1, 0, 0);
    chk("err_pulse_hi", refill_err_o, 1);
    idle();
    chk("err_pulse_lo", refill_err_o, 0);

    // Merge in the same cycle as the refill is still replayed.
    step(1, 34'h500, 1, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0, 0);
    step(1, 34'h500, 0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 0, 1, 0);
    chk("same_cycle_merge_freed", empty_o, 1);

    // Random traffic over a small line pool so merges and stalls are frequent.
    for (int c = 0; c < 3000; c++) begin
      w  = lowest_wait();
      fv = ($urandom_range(0, 9) < 3);
      if (w >= 0 && $urandom_range(0, 9) < 8) begin
        fid = $urandom_range(0, NE - 1);
        if (m_st[fid] != S_WAIT) fid = w;
      end else begin
        fid = $urandom_range(0, NE - 1);
      end
      step($urandom_range(0, 1), 34'h40 + 34'($urandom_range(0, 5)), $urandom_range(0, 1),
           fv, fid, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 3);
    end
    drain_all();

    // Asynchronous reset in the middle of activity.
    step(1, 34'h77, 0, 0, 0, 0, 0);
    step(1, 34'h78, 1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_empty", empty_o, 1);
    chk("async_rst_mem_vld", mem_req_vld_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step(1, 34'h79, 0, 0, 0, 0, 0);
    idle();
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
